// File: rtl/dm_access_ctrl.sv
// dm_access_ctrl: sequences MEM-stage loads/stores onto a word-write-only RAM,
// doing read-modify-write for sub-word stores and bounding every RAM wait.
module dm_access_ctrl #(
    parameter int ADDR_W   = 10,
    parameter int MAX_WAIT = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              mem_req,
    input  logic              mem_we,
    input  logic [2:0]        mem_op,
    input  logic [31:0]       mem_addr,
    input  logic [31:0]       mem_wdata,
    output logic              stall,
    output logic [31:0]       rdata,
    output logic [1:0]        rdata_a,
    output logic [2:0]        rdata_op,
    output logic              rdata_valid,
    output logic              adel,
    output logic              ades,
    output logic              bus_err,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_re,
    output logic              ram_we,
    output logic [31:0]       ram_wdata,
    input  logic [31:0]       ram_rdata,
    input  logic              ram_ready
);

    localparam int CNT_W = $clog2(MAX_WAIT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_WAIT - 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_READ   = 3'd1;
    localparam logic [2:0] S_WRITE  = 3'd2;
    localparam logic [2:0] S_RMW_RD = 3'd3;
    localparam logic [2:0] S_RMW_WR = 3'd4;
    localparam logic [2:0] S_DONE   = 3'd5;

    function automatic logic is_byte(input logic [2:0] op);
        return (op == 3'b001) || (op == 3'b010);
    endfunction

    function automatic logic is_half(input logic [2:0] op);
        return (op == 3'b011) || (op == 3'b100);
    endfunction

    logic [2:0]        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W+1:0] addr_q, addr_d;
    logic [2:0]        op_q, op_d;
    logic              st_q, st_d;
    logic [15:0]       wsub_q, wsub_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              err_q, err_d;
    logic              re_q, re_d;
    logic              we_q, we_d;
    logic [31:0]       wdat_q, wdat_d;

    logic        req_byte, req_half, req_mis;
    logic        idle, busy, timeout;
    logic [31:0] merged;
    logic        unused_addr;

    // Upper address bits lie outside the RAM and are deliberately dropped.
    assign unused_addr = ^mem_addr[31:ADDR_W+2];

    always_comb begin
        req_byte = is_byte(mem_op);
        req_half = is_half(mem_op);
        unique case (1'b1)
            req_byte: req_mis = 1'b0;
            req_half: req_mis = mem_addr[0];
            default:  req_mis = |mem_addr[1:0];
        endcase
    end

    always_comb begin
        merged = ram_rdata;
        if (is_byte(op_q)) begin
            merged[{addr_q[1:0], 3'b000} +: 8] = wsub_q[7:0];
        end else begin
            merged[{addr_q[1], 4'b0000} +: 16] = wsub_q;
        end
    end

    assign idle    = (state_q == S_IDLE);
    assign busy    = (state_q == S_READ)   || (state_q == S_WRITE) ||
                     (state_q == S_RMW_RD) || (state_q == S_RMW_WR);
    assign timeout = busy && !ram_ready && (cnt_q == CNT_LAST);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        op_d    = op_q;
        st_d    = st_q;
        wsub_d  = wsub_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        re_d    = re_q;
        we_d    = we_q;
        wdat_d  = wdat_q;
        case (state_q)
            S_IDLE: begin
                if (mem_req && !req_mis) begin
                    addr_d = mem_addr[ADDR_W+1:0];
                    op_d   = mem_op;
                    st_d   = mem_we;
                    wsub_d = mem_wdata[15:0];
                    cnt_d  = '0;
                    err_d  = 1'b0;
                    if (!mem_we) begin
                        state_d = S_READ;
                        re_d    = 1'b1;
                    end else if (req_byte || req_half) begin
                        state_d = S_RMW_RD;
                        re_d    = 1'b1;
                    end else begin
                        state_d = S_WRITE;
                        we_d    = 1'b1;
                        wdat_d  = mem_wdata;
                    end
                end
            end
            S_READ: begin
                if (ram_ready) begin
                    rdata_d = ram_rdata;
                    re_d    = 1'b0;
                    state_d = S_DONE;
                end
            end
            S_WRITE, S_RMW_WR: begin
                if (ram_ready) begin
                    we_d    = 1'b0;
                    state_d = S_DONE;
                end
            end
            S_RMW_RD: begin
                if (ram_ready) begin
                    re_d    = 1'b0;
                    we_d    = 1'b1;
                    wdat_d  = merged;
                    cnt_d   = '0;
                    state_d = S_RMW_WR;
                end
            end
            default: state_d = S_IDLE;
        endcase
        // A stuck RAM abandons the access; nothing is committed.
        if (timeout) begin
            re_d    = 1'b0;
            we_d    = 1'b0;
            rdata_d = '0;
            err_d   = 1'b1;
            state_d = S_DONE;
        end else if (busy && !ram_ready) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            op_q    <= '0;
            st_q    <= 1'b0;
            wsub_q  <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            re_q    <= 1'b0;
            we_q    <= 1'b0;
            wdat_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            op_q    <= op_d;
            st_q    <= st_d;
            wsub_q  <= wsub_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            re_q    <= re_d;
            we_q    <= we_d;
            wdat_q  <= wdat_d;
        end
    end

    assign stall       = busy || (idle && mem_req && !req_mis);
    assign adel        = idle && mem_req && req_mis && !mem_we;
    assign ades        = idle && mem_req && req_mis && mem_we;
    assign rdata_valid = (state_q == S_DONE) && !st_q && !err_q;
    assign bus_err     = (state_q == S_DONE) && err_q;
    assign rdata       = rdata_q;
    assign rdata_a     = addr_q[1:0];
    assign rdata_op    = op_q;
    assign ram_addr    = addr_q[ADDR_W+1:2];
    assign ram_re      = re_q;
    assign ram_we      = we_q;
    assign ram_wdata   = wdat_q;

endmodule

// File: tb/tb_dm_access_ctrl.sv
// tb_dm_access_ctrl: directed and randomized checks of dm_access_ctrl
// against a word-array memory model and store-merge arithmetic.
module tb_dm_access_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_req, mem_we;
    logic [2:0]  mem_op;
    logic [31:0] mem_addr, mem_wdata;
    logic        stall, rdata_valid, adel, ades, bus_err;
    logic [31:0] rdata;
    logic [1:0]  rdata_a;
    logic [2:0]  rdata_op;
    logic [9:0]  ram_addr;
    logic        ram_re, ram_we;
    logic [31:0] ram_wdata, ram_rdata;
    logic        ram_ready = 1'b0;

    int total = 0;
    int bad = 0;
    int rdy_mode = 1;

    logic [31:0] ram [0:1023];
    logic [31:0] ref_mem [0:1023];

    dm_access_ctrl dut (
        .clk(clk), .reset(reset),
        .mem_req(mem_req), .mem_we(mem_we), .mem_op(mem_op),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .stall(stall), .rdata(rdata), .rdata_a(rdata_a),
        .rdata_op(rdata_op), .rdata_valid(rdata_valid),
        .adel(adel), .ades(ades), .bus_err(bus_err),
        .ram_addr(ram_addr), .ram_re(ram_re), .ram_we(ram_we),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
        .ram_ready(ram_ready)
    );

    always #5 clk = ~clk;

    assign ram_rdata = ram[ram_addr];

    always @(posedge clk) begin
        if (ram_we && ram_ready) ram[ram_addr] <= ram_wdata;
    end

    always @(negedge clk) begin
        case (rdy_mode)
            0: ram_ready = 1'b0;
            1: ram_ready = 1'b1;
            default: ram_ready = ($urandom_range(3) != 0);
        endcase
    end

    function automatic logic [31:0] store_model(input logic [31:0] old,
        input logic [2:0] op, input logic [1:0] a, input logic [31:0] wd);
        logic [31:0] mask;
        int sh;
        if (op == 3'd1 || op == 3'd2) begin
            sh = 8 * int'(a);
            mask = 32'hFF << sh;
            return (old & ~mask) | ((wd & 32'hFF) << sh);
        end
        if (op == 3'd3 || op == 3'd4) begin
            sh = 16 * int'(a[1]);
            mask = 32'hFFFF << sh;
            return (old & ~mask) | ((wd & 32'hFFFF) << sh);
        end
        return wd;
    endfunction

    task automatic run_access(input logic we, input logic [2:0] op,
        input logic [31:0] addr, input logic [31:0] wd,
        output int stalls, output logic v, output logic [31:0] rd,
        output logic [1:0] ra, output logic [2:0] rop,
        output logic err, output logic el, output logic es);
        int guard;
        @(negedge clk);
        mem_req = 1'b1; mem_we = we; mem_op = op;
        mem_addr = addr; mem_wdata = wd;
        #1;
        el = adel; es = ades;
        stalls = 0; guard = 0;
        v = 1'b0; rd = '0; ra = '0; rop = '0; err = 1'b0;
        if (stall) begin
            while (stall && guard < 100) begin
                stalls++; guard++;
                total++;
                if (ram_re && ram_we) begin
                    bad++;
                    $display("FAIL strobe_excl re=%b we=%b required not both 1", ram_re, ram_we);
                end
                @(negedge clk);
                #1;
            end
            total++;
            if (guard >= 100) begin
                bad++;
                $display("FAIL completion stall still %b after %0d cycles, required 0", stall, guard);
            end
            v = rdata_valid; rd = rdata; ra = rdata_a;
            rop = rdata_op; err = bus_err;
        end
        @(negedge clk);
        mem_req = 1'b0;
        #1;
        total++;
        if ({ram_re, ram_we, rdata_valid, bus_err, stall} !== 5'b0) begin
            bad++;
            $display("FAIL idle_after re/we/valid/err/stall=%b required 00000",
                     {ram_re, ram_we, rdata_valid, bus_err, stall});
        end
    endtask

    task automatic check_access(input logic we, input logic [2:0] op,
        input logic [31:0] addr, input logic [31:0] wd, input logic fixed_rdy);
        logic sub_b, sub_h, mis, v, err, el, es;
        logic [31:0] old, rd;
        logic [1:0] ra;
        logic [2:0] rop;
        int w, stalls, exp_st;
        sub_b = (op == 3'd1 || op == 3'd2);
        sub_h = (op == 3'd3 || op == 3'd4);
        mis = sub_b ? 1'b0 : sub_h ? addr[0] : (addr[1:0] != 2'b00);
        w = int'(addr[11:2]);
        old = ref_mem[w];
        run_access(we, op, addr, wd, stalls, v, rd, ra, rop, err, el, es);
        total++;
        if ({el, es} !== {mis & ~we, mis & we}) begin
            bad++;
            $display("FAIL except addr=%h adel/ades=%b%b required %b%b",
                     addr, el, es, mis & ~we, mis & we);
        end
        if (!mis && we) ref_mem[w] = store_model(old, op, addr[1:0], wd);
        total++;
        if (ram[w] !== ref_mem[w]) begin
            bad++;
            $display("FAIL ram_word addr=%h got %h required %h", addr, ram[w], ref_mem[w]);
        end
        exp_st = mis ? 0 : (we && (sub_b || sub_h)) ? 3 : 2;
        if (fixed_rdy || mis) begin
            total++;
            if (stalls != exp_st) begin
                bad++;
                $display("FAIL latency addr=%h stalls=%0d required %0d", addr, stalls, exp_st);
            end
        end
        total++;
        if (v !== (!mis && !we) || err !== 1'b0) begin
            bad++;
            $display("FAIL valid addr=%h valid=%b err=%b required %b 0", addr, v, err, !mis && !we);
        end
        if (!mis && !we) begin
            total++;
            if (rd !== old || ra !== addr[1:0] || rop !== op) begin
                bad++;
                $display("FAIL load addr=%h got %h/%0d/%0d required %h/%0d/%0d",
                         addr, rd, ra, rop, old, addr[1:0], op);
            end
        end
    endtask

    task automatic set_word(input int w, input logic [31:0] val);
        ram[w] = val;
        ref_mem[w] = val;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        mem_req = 1'b0; mem_we = 1'b0; mem_op = '0;
        mem_addr = '0; mem_wdata = '0;
        for (int i = 0; i < 1024; i++) set_word(i, $urandom);
        @(negedge clk);
        #1;
        total++;
        if ({stall, rdata_valid, adel, ades, bus_err, ram_re, ram_we} !== 7'b0) begin
            bad++;
            $display("FAIL reset_flags got %b required 0",
                     {stall, rdata_valid, adel, ades, bus_err, ram_re, ram_we});
        end
        total++;
        if ({rdata, rdata_a, rdata_op, ram_addr, ram_wdata} !== '0) begin
            bad++;
            $display("FAIL reset_data rdata=%h addr=%h wdata=%h required 0",
                     rdata, ram_addr, ram_wdata);
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_lw();
        int stalls;
        logic v, err, el, es;
        logic [31:0] rd;
        logic [1:0] ra;
        logic [2:0] rop;
        rdy_mode = 1;
        set_word(4, 32'hAABBCCDD);
        run_access(1'b0, 3'b000, 32'h10, 32'h0, stalls, v, rd, ra, rop, err, el, es);
        total++;
        if (stalls != 2 || v !== 1'b1 || rd !== 32'hAABBCCDD || ra !== 2'd0) begin
            bad++;
            $display("FAIL lw_10 stalls=%0d valid=%b rdata=%h a=%0d required 2 1 aabbccdd 0",
                     stalls, v, rd, ra);
        end
    endtask

    task automatic test_sub_store();
        rdy_mode = 1;
        set_word(4, 32'h11223344);
        check_access(1'b1, 3'b010, 32'h13, 32'h5A, 1'b1);
        total++;
        if (ram[4] !== 32'h5A223344) begin
            bad++;
            $display("FAIL sb_13 ram=%h required 5a223344", ram[4]);
        end
        set_word(3, 32'h01020304);
        check_access(1'b1, 3'b011, 32'h0E, 32'hBEEF, 1'b1);
        total++;
        if (ram[3] !== 32'hBEEF0304) begin
            bad++;
            $display("FAIL sh_0e ram=%h required beef0304", ram[3]);
        end
    endtask

    task automatic test_misaligned();
        rdy_mode = 1;
        check_access(1'b0, 3'b100, 32'h21, 32'h0, 1'b1);
        check_access(1'b1, 3'b000, 32'h22, 32'hDEADBEEF, 1'b1);
    endtask

    task automatic test_timeout();
        int stalls;
        logic v, err, el, es;
        logic [31:0] rd;
        logic [1:0] ra;
        logic [2:0] rop;
        rdy_mode = 0;
        run_access(1'b0, 3'b000, 32'h10, 32'h0, stalls, v, rd, ra, rop, err, el, es);
        total++;
        if (stalls != 16 || err !== 1'b1 || v !== 1'b0 || rd !== 32'h0) begin
            bad++;
            $display("FAIL timeout stalls=%0d err=%b valid=%b rdata=%h required 16 1 0 0",
                     stalls, err, v, rd);
        end
        rdy_mode = 1;
        check_access(1'b0, 3'b000, 32'h10, 32'h0, 1'b1);
    endtask

    task automatic test_reset_mid();
        logic [31:0] old;
        old = ref_mem[5];
        rdy_mode = 0;
        @(negedge clk);
        mem_req = 1'b1; mem_we = 1'b1; mem_op = 3'b001;
        mem_addr = 32'h15; mem_wdata = 32'hA5;
        @(negedge clk);
        mem_req = 1'b0;
        #1;
        total++;
        if (ram_re !== 1'b1 || stall !== 1'b1) begin
            bad++;
            $display("FAIL rmw_rd_busy re=%b stall=%b required 1 1", ram_re, stall);
        end
        reset = 1'b1;
        #1;
        total++;
        if ({ram_re, ram_we, stall, rdata_valid, bus_err} !== 5'b0 ||
            ram_addr !== '0 || rdata !== '0) begin
            bad++;
            $display("FAIL reset_mid re/we/stall/valid/err=%b addr=%h rdata=%h required 0",
                     {ram_re, ram_we, stall, rdata_valid, bus_err}, ram_addr, rdata);
        end
        @(negedge clk);
        reset = 1'b0;
        rdy_mode = 1;
        total++;
        if (ram[5] !== old) begin
            bad++;
            $display("FAIL reset_mid_ram got %h required %h", ram[5], old);
        end
        check_access(1'b0, 3'b000, 32'h14, 32'h0, 1'b1);
    endtask

    task automatic test_back_to_back();
        rdy_mode = 1;
        for (int i = 0; i < 12; i++) begin
            check_access(1'($urandom_range(1)), 3'($urandom_range(7)),
                         {$urandom, 2'b00} | 32'($urandom_range(3) & (i % 2)),
                         $urandom, 1'b1);
        end
    endtask

    task automatic test_random();
        rdy_mode = 2;
        for (int i = 0; i < 40; i++) begin
            check_access(1'($urandom_range(1)), 3'($urandom_range(7)),
                         $urandom, $urandom, 1'b0);
        end
        rdy_mode = 1;
    endtask

    initial begin
        test_reset();
        test_lw();
        test_sub_store();
        test_misaligned();
        test_timeout();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
